alu_seq: RTL and testbench

Parametrised multi-cycle ALU, the successor to the processor's combinational accumulator ALU. Data width is generic. Shifts run iteratively, one bit per cycle. A new shift-add multiply produces a double-width product. Add and subtract can chain through a registered carry flag for multi-word arithmetic. The controller drives it through a `start` / `ready` / `done` handshake, and results and flags are held in registers until the next completion.

---
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with iterative shifts, shift-add multiply and chained carry.
// Results and flags are registered and change only on a completing edge.
module alu_seq #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] in_acc,
  input  logic [W-1:0] in_opr,
  input  logic         use_carry,
  input  logic         ld_immed,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] mul_hi,
  output logic         cout,
  output logic         zero,
  output logic         pari
);
  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] sh, sh_nx, mq, mq_nx, mm, ma, ma_nx;
  logic [W:0] sum, madd;
  logic [SHW-1:0] cnt;
  logic dir, cin, sh_out, single, fin;
  logic [W-1:0] s_res, f_res, f_hi;
  logic s_cout, f_cout;
  assign ready = (state == IDLE) || (state == DONE);
  assign done = (state == DONE);
  assign single = ld_immed || (op != 4'h0 && op != 4'hE);
  assign cin = use_carry ? cout : op[0];
  assign sum = {1'b0, in_acc} + {1'b0, op[0] ? ~in_opr : in_opr} + {{W{1'b0}}, cin};
  assign sh_nx = dir ? {sh[W-1], sh[W-1:1]} : {sh[W-2:0], 1'b0};
  assign sh_out = dir ? sh[0] : sh[W-1];
  assign madd = {1'b0, ma} + (mq[0] ? {1'b0, mm} : {(W+1){1'b0}});
  assign ma_nx = madd[W:1];
  assign mq_nx = {madd[0], mq[W-1:1]};
  // Pass-through and logic ops clear the carry flag alike.
  always_comb begin
    s_cout = 1'b0;
    s_res = in_acc;
    if (ld_immed) s_res = in_opr;
    else
      case (op)
        4'h4, 4'h5, 4'h6: s_res = in_opr;
        4'h8: s_res = in_acc & in_opr;
        4'h9: s_res = in_acc | in_opr;
        4'hA: s_res = in_acc ^ in_opr;
        4'hB: s_res = ~in_opr;
        4'hC, 4'hD: {s_cout, s_res} = sum;
        4'hF: s_res = '0;
        default: s_res = in_acc;
      endcase
  end
  always_comb begin
    state_nx = state;
    fin = 1'b0;
    f_res = s_res;
    f_hi = '0;
    f_cout = s_cout;
    case (state)
      IDLE, DONE:
        if (start) begin
          state_nx = single ? DONE : (op == 4'h0) ? SHIFT : MUL;
          fin = single;
        end else state_nx = IDLE;
      SHIFT:
        if (cnt == '0) begin
          state_nx = DONE;
          fin = 1'b1;
          f_res = sh_nx;
          f_cout = sh_out;
        end
      MUL:
        if (cnt == '0) begin
          state_nx = DONE;
          fin = 1'b1;
          f_res = mq_nx;
          f_hi = ma_nx;
          f_cout = |ma_nx;
        end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
      mq <= '0;
      mm <= '0;
      ma <= '0;
      cnt <= '0;
      dir <= 1'b0;
      result <= '0;
      mul_hi <= '0;
      cout <= 1'b0;
      zero <= 1'b1;
      pari <= 1'b0;
    end else begin
      if (ready && start) begin
        sh <= in_acc;
        dir <= in_opr[SHW];
        cnt <= (op == 4'h0) ? in_opr[SHW-1:0] : SHW'(W - 1);
        mq <= in_opr;
        mm <= in_acc;
        ma <= '0;
      end else if (state == SHIFT) begin
        sh <= sh_nx;
        cnt <= cnt - 1'b1;
      end else if (state == MUL) begin
        mq <= mq_nx;
        ma <= ma_nx;
        cnt <= cnt - 1'b1;
      end
      if (fin) begin
        result <= f_res;
        mul_hi <= f_hi;
        cout <= f_cout;
        zero <= (f_res == '0);
        pari <= ^f_res;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  logic clk = 0, rst_n = 0;
  logic start = 0, use_carry = 0, ld_immed = 0;
  logic [3:0] op = 0;
  logic [7:0] in_acc = 0, in_opr = 0;
  logic ready, done, cout, zero, pari;
  logic [7:0] result, mul_hi;
  logic start16 = 0;
  logic [15:0] acc16 = 0, opr16 = 0;
  logic ready16, done16, cout16, zero16, pari16;
  logic [15:0] result16, hi16;
  int total = 0, bad = 0;
  bit chk_on = 0;
  logic [7:0] e_res = 0, e_hi = 0, p_res, p_hi;
  logic e_cout = 0, e_ready = 1, e_done = 0, p_cout;
  int left = 0;
  alu_seq #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .in_acc(in_acc),
    .in_opr(in_opr), .use_carry(use_carry), .ld_immed(ld_immed), .ready(ready), .done(done),
    .result(result), .mul_hi(mul_hi), .cout(cout), .zero(zero), .pari(pari));
  alu_seq #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .start(start16), .op(4'h0), .in_acc(acc16),
    .in_opr(opr16), .use_carry(1'b0), .ld_immed(1'b0), .ready(ready16), .done(done16),
    .result(result16), .mul_hi(hi16), .cout(cout16), .zero(zero16), .pari(pari16));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  function automatic void model_op(input logic [3:0] o, input logic [7:0] a, b,
      input logic uc, li, cr, output logic [7:0] r, h, output logic c, output int lat);
    int k;
    logic ci;
    logic [15:0] p;
    r = a; h = 0; c = 0; lat = 0;
    k = int'(b[2:0]) + 1;
    ci = uc ? cr : (o == 4'hD);
    if (li) r = b;
    else
      case (o)
        4'h0: begin
          lat = k;
          if (b[3]) begin r = 8'($signed(a) >>> k); c = a[k-1]; end
          else begin r = a << k; c = a[8-k]; end
        end
        4'h4, 4'h5, 4'h6: r = b;
        4'h8: r = a & b;
        4'h9: r = a | b;
        4'hA: r = a ^ b;
        4'hB: r = ~b;
        4'hC: {c, r} = {1'b0, a} + {1'b0, b} + 9'(ci);
        4'hD: {c, r} = {1'b0, a} + {1'b0, ~b} + 9'(ci);
        4'hE: begin p = 16'(a) * 16'(b); r = p[7:0]; h = p[15:8]; c = |h; lat = 8; end
        4'hF: r = 0;
        default: r = a;
      endcase
  endfunction
  // Reference: acceptance when idle, completion after the op's latency.
  always @(posedge clk or negedge rst_n) begin
    logic [7:0] r, h;
    logic c;
    int lat;
    if (!rst_n) begin
      e_res = 0; e_hi = 0; e_cout = 0; e_ready = 1; e_done = 0; left = 0;
    end else if (left > 0) begin
      left--;
      e_done = (left == 0);
      if (left == 0) begin e_res = p_res; e_hi = p_hi; e_cout = p_cout; e_ready = 1; end
    end else if (start) begin
      model_op(op, in_acc, in_opr, use_carry, ld_immed, e_cout, r, h, c, lat);
      if (lat == 0) begin e_res = r; e_hi = h; e_cout = c; e_done = 1; end
      else begin p_res = r; p_hi = h; p_cout = c; left = lat; e_done = 0; e_ready = 0; end
    end else e_done = 0;
  end
  always @(negedge clk)
    if (chk_on) begin
      chk("ready", ready, e_ready);
      chk("done", done, e_done);
      chk("result", result, e_res);
      chk("mul_hi", mul_hi, e_hi);
      chk("cout", cout, e_cout);
      chk("zero", zero, e_res == 0);
      chk("pari", pari, ^e_res);
    end
  task automatic issue(input logic [3:0] o, input logic [7:0] a, b, input logic uc, li);
    op = o; in_acc = a; in_opr = b; use_carry = uc; ld_immed = li; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_on = 1;
    chk("rst_ready", ready, 1); chk("rst_zero", zero, 1); chk("rst_result", result, 0);
    rst_n = 1;
    @(negedge clk);
    issue(4'hC, 8'hFF, 8'h01, 0, 0);
    chk("add_done", done, 1); chk("add_res", result, 8'h00);
    chk("add_cout", cout, 1); chk("add_zero", zero, 1);
    issue(4'hC, 8'h00, 8'h00, 1, 0);
    chk("adc_done", done, 1); chk("adc_res", result, 8'h01);
    chk("adc_cout", cout, 0); chk("adc_pari", pari, 1);
    issue(4'h0, 8'h81, 8'b1010, 0, 0);
    wait_done(0, n);
    chk("asr_lat", n, 3); chk("asr_res", result, 8'hF0); chk("asr_cout", cout, 0);
    issue(4'h0, 8'h81, 8'b0000, 0, 0);
    wait_done(0, n);
    chk("shl1_lat", n, 1); chk("shl1_res", result, 8'h02); chk("shl1_cout", cout, 1);
    issue(4'h0, 8'h81, 8'b0111, 0, 0);
    wait_done(0, n);
    chk("shl8_lat", n, 8); chk("shl8_res", result, 8'h00); chk("shl8_cout", cout, 1);
    issue(4'hE, 8'hFF, 8'hFF, 0, 0);
    op = 4'hC; in_acc = 8'h01; in_opr = 8'h01; start = 1;
    n = 0;
    repeat (2) begin chk("mul_busy", ready, 0); @(negedge clk); n++; end
    start = 0;
    wait_done(n, n);
    chk("mul_lat", n, 8); chk("mul_res", result, 8'h01);
    chk("mul_hi", mul_hi, 8'hFE); chk("mul_cout", cout, 1);
    issue(4'hE, 8'h00, 8'h5A, 0, 1);
    chk("imm_done", done, 1); chk("imm_res", result, 8'h5A); chk("imm_hi", mul_hi, 8'h00);
    issue(4'hE, 8'h0F, 8'h11, 0, 0);
    wait_done(0, n);
    chk("mul2_res", result, 8'hFF); chk("mul2_hi", mul_hi, 8'h00); chk("mul2_cout", cout, 0);
    issue(4'hE, 8'hFF, 8'hFF, 0, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_res", result, 0); chk("abort_hi", mul_hi, 0); chk("abort_cout", cout, 0);
    chk("abort_zero", zero, 1); chk("abort_pari", pari, 0);
    chk("abort_done", done, 0); chk("abort_ready", ready, 1);
    @(negedge clk);
    rst_n = 1;
    issue(4'hD, 8'h05, 8'h07, 0, 0);
    chk("sub_done", done, 1); chk("sub_res", result, 8'hFE); chk("sub_cout", cout, 0);
    acc16 = 16'h8001; opr16 = 16'h001F; start16 = 1;
    @(negedge clk);
    start16 = 0;
    n = 0;
    while (!done16 && n < 100) begin @(negedge clk); n++; end
    chk("w16_lat", n, 16); chk("w16_res", result16, 16'hFFFF); chk("w16_cout", cout16, 1);
    repeat (1500) begin
      start = ($urandom_range(0, 2) != 0);
      op = 4'($urandom);
      in_acc = 8'($urandom);
      in_opr = 8'($urandom);
      use_carry = 1'($urandom);
      ld_immed = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start = 0;
    repeat (12) @(negedge clk);
    chk("final_ready", ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
